// File: rtl/ddr_rb_pkg.sv
// Shared definitions for the DDR readback engine: FSM encoding and default widths.
package ddr_rb_pkg;
  localparam int RB_ADX_W      = 27;
  localparam int RB_DATA_W     = 128;
  localparam int RB_ADX_STRIDE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/ddr_readback_engine_if.sv
// Memory-interface read port and upload stream bundles used by the readback engine.
interface ddr_rb_mem_if
  import ddr_rb_pkg::*;
#(
  parameter int ADX_W  = RB_ADX_W,
  parameter int DATA_W = RB_DATA_W
);
  logic [ADX_W-1:0]  rd_adx_in;
  logic              read_req;
  logic              read_allowed;
  logic [DATA_W-1:0] rd_data_return;
  logic [ADX_W-1:0]  rd_adx_return;
  logic              has_return_data;
  logic              get_return_data;

  modport master (
    output rd_adx_in, read_req, get_return_data,
    input  read_allowed, rd_data_return, rd_adx_return, has_return_data
  );
  modport slave (
    input  rd_adx_in, read_req, get_return_data,
    output read_allowed, rd_data_return, rd_adx_return, has_return_data
  );
endinterface

interface ddr_rb_stream_if
  import ddr_rb_pkg::*;
#(
  parameter int ADX_W  = RB_ADX_W,
  parameter int DATA_W = RB_DATA_W
);
  logic [DATA_W-1:0] out_data;
  logic [ADX_W-1:0]  out_adx;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, out_adx, out_valid, input out_ready);
  modport slave  (input out_data, out_adx, out_valid, output out_ready);
endinterface

// File: rtl/ddr_rb_out_stage.sv
// Single-entry valid/ready output register; can_load says a new word may enter this cycle.
module ddr_rb_out_stage
  import ddr_rb_pkg::*;
#(
  parameter int ADX_W  = RB_ADX_W,
  parameter int DATA_W = RB_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADX_W-1:0]  in_adx,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADX_W-1:0]  out_adx,
  output logic              can_load
);
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [ADX_W-1:0]  adx_p0;

  assign can_load  = !vld_p0 || out_ready;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_adx   = adx_p0;

  // Stage p0: holds the word until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      adx_p0  <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
      adx_p0  <= in_adx;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end
endmodule

// File: rtl/ddr_readback_engine.sv
// Issues sequential DDR reads under a credit limit, checks return order, streams words out.
module ddr_readback_engine
  import ddr_rb_pkg::*;
#(
  parameter int ADX_W           = RB_ADX_W,
  parameter int DATA_W          = RB_DATA_W,
  parameter int ADX_STRIDE      = RB_ADX_STRIDE,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [ADX_W-1:0] start_adx,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  ddr_rb_mem_if.master     mem,
  ddr_rb_stream_if.master  strm
);
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e             state, state_nxt;
  logic [ADX_W-1:0]   next_req_adx, exp_adx;
  logic [CNT_W-1:0]   count, issued, received;
  logic [OCNT_W-1:0]  outstanding;
  logic               error_r, done_r;
  logic               issue, pop, load, can_load, last_acc;

  assign busy                = (state == ST_RUN);
  assign done                = done_r;
  assign error               = error_r;
  assign mem.read_req        = issue;
  assign mem.get_return_data = pop;
  assign mem.rd_adx_in       = next_req_adx;
  assign load                = pop && (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    last_acc  = (received == count) && can_load;
    case (state)
      ST_IDLE: begin
        // Stale returns from an aborted run are drained and dropped here.
        pop = mem.has_return_data;
        if (start && (word_count != '0)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        issue = (issued != count) && (outstanding < OCNT_W'(MAX_OUTSTANDING)) && mem.read_allowed;
        pop   = mem.has_return_data && can_load;
        if (last_acc) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_req_adx <= '0;
      exp_adx      <= '0;
      count        <= '0;
      issued       <= '0;
      received     <= '0;
      outstanding  <= '0;
      error_r      <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == ST_IDLE && start) begin
        if (word_count == '0) begin
          done_r <= 1'b1;
        end else begin
          next_req_adx <= start_adx;
          exp_adx      <= start_adx;
          count        <= word_count;
          issued       <= '0;
          received     <= '0;
          outstanding  <= '0;
          error_r      <= 1'b0;
        end
      end
      if (state == ST_RUN) begin
        if (issue) begin
          issued       <= issued + CNT_W'(1);
          next_req_adx <= next_req_adx + ADX_W'(ADX_STRIDE);
        end
        if (pop) begin
          received <= received + CNT_W'(1);
          exp_adx  <= exp_adx + ADX_W'(ADX_STRIDE);
          // Out-of-order or unrequested data is flagged but still forwarded.
          if ((mem.rd_adx_return != exp_adx) || (outstanding == '0)) error_r <= 1'b1;
        end
        case ({issue, pop})
          2'b10:   outstanding <= outstanding + OCNT_W'(1);
          2'b01:   if (outstanding != '0) outstanding <= outstanding - OCNT_W'(1);
          default: outstanding <= outstanding;
        endcase
        if (last_acc) done_r <= 1'b1;
      end
    end
  end

  ddr_rb_out_stage #(.ADX_W(ADX_W), .DATA_W(DATA_W)) u_out_stage (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .in_data   (mem.rd_data_return),
    .in_adx    (mem.rd_adx_return),
    .out_ready (strm.out_ready),
    .out_valid (strm.out_valid),
    .out_data  (strm.out_data),
    .out_adx   (strm.out_adx),
    .can_load  (can_load)
  );
endmodule

// File: doc/ddr_readback_engine.md
Name: ddr_readback_engine

Overview:
- Read-side client of the DDR memory interface command/return ports.
- Given a start address and word count, it issues sequential 128-bit read requests under a credit limit.
- It pops returned data and checks address order.
- It presents words on a valid/ready stream to the capture upload path, e.g. the UART/host dump. Sits between the memory interface and the host-facing readout logic, all on soc_clk.

Parameters:
- ADX_W, 27, address width (matches memory interface).
- DATA_W, 128, data word width.
- ADX_STRIDE, 8, address increment per 128-bit word (8 x 16-bit columns).
- MAX_OUTSTANDING, 8, maximum issued-but-not-popped reads; power of 2, >= 1.
- CNT_W, 24, word count width.

Ports:
- clk  in  1  soc_clk.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- start_adx  in  ADX_W  first read address; sampled on start.
- word_count  in  CNT_W  number of words to read; sampled on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky return-address mismatch; cleared on next accepted start.
- rd_adx_in  out  ADX_W  read request address (to memory interface rd_adx_in).
- read_req  out  1  read request.
- read_allowed  in  1  memory interface can accept a read this cycle.
- rd_data_return  in  DATA_W  head return data.
- rd_adx_return  in  ADX_W  head return address.
- has_return_data  in  1  return data available.
- get_return_data  out  1  pop head of return buffer.
- out_data  out  DATA_W  stream data.
- out_adx  out  ADX_W  address of out_data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.

Behaviour:
- Reset: all registers cleared. State IDLE; busy, done, error, read_req, get_return_data, out_valid = 0; out_data, out_adx, rd_adx_in = 0. Outstanding, issued and received counters = 0.
- States: IDLE, RUN, FIN.
- IDLE transitions:
  - start with word_count != 0 -> RUN.
    - Latch next_req_adx = start_adx and exp_adx = start_adx.
    - Latch remaining count; clear counters and error.
  - start with word_count == 0 -> done = 1 next cycle; stay IDLE; busy stays 0.
- IDLE flush: if has_return_data is high (stale returns after reset/abort), assert get_return_data and discard. No stream output, no error.
- RUN, request issue:
  - read_req = (issued != count) && (outstanding < MAX_OUTSTANDING) && read_allowed.
  - Combinational from registers and read_allowed; rd_adx_in = next_req_adx (registered).
  - A request is accepted in the same cycle read_req is high. On acceptance: issued += 1; next_req_adx += ADX_STRIDE, modulo 2^ADX_W (wraps silently).
- RUN, return pop:
  - get_return_data = has_return_data && (!out_valid || out_ready).
  - On pop, the next cycle has:
    - out_data = rd_data_return;
    - out_adx = rd_adx_return;
    - out_valid = 1;
    - received += 1;
    - exp_adx += ADX_STRIDE.
  - If rd_adx_return != exp_adx on pop, error = 1 (sticky) and the word is still forwarded.
- Outstanding counter: +1 on issue, -1 on pop; simultaneous issue and pop leaves it unchanged. Never exceeds MAX_OUTSTANDING and never underflows; a pop when outstanding == 0 sets error.
- Stream rule: out_valid stays high until out_ready. out_data/out_adx are stable while out_valid && !out_ready.
- Throughput: 1 word/cycle sustained when read_allowed, has_return_data and out_ready are continuously high.
- RUN -> FIN when received == count and the last word has been accepted (out_valid && out_ready, or out_valid already 0).
- FIN: done = 1 for one cycle, busy = 0 -> IDLE.
- busy = 1 in RUN and FIN-entry; busy = 0 in the cycle done is high.
- Latency: start to first read_req is 1 cycle. Pop to out_valid is 1 cycle.
- Reset mid-run: the block returns to IDLE immediately. In-flight returns are flushed by the IDLE rule.

Decomposition:
- Shared package ddr_rb_pkg: state encoding (IDLE, RUN, FIN); ADX_W, DATA_W, ADX_STRIDE defaults.
- One sub-module, ddr_rb_out_stage: single-entry valid/ready output register with a can_load output. It provides the (!out_valid || out_ready) term.

Test Plan:
- Basic read: start_adx = 0x100, count = 4, read_allowed = 1, returns in order, out_ready = 1.
  - Requires read_req at 0x100, 0x108, 0x110, 0x118.
  - Requires 4 stream words with out_adx matching, then done pulse, error = 0.
- Credit limit: count = 20, has_return_data held 0.
  - Requires exactly 8 read_req accepts, then read_req = 0.
  - After releasing returns, all 20 complete.
- Backpressure: count = 6, out_ready toggles 1/0 each cycle.
  - Requires out_data stable during stalls.
  - Requires get_return_data only when the stage can load, no lost or duplicated words.
- Wrap and mismatch:
  - start_adx = 0x7FFFFF8, count = 2 -> second request address 0x0000000.
  - A separate run returning 0x200 when 0x208 is expected -> error = 1 and held until the next start.
- Zero count and busy start:
  - word_count = 0 -> done next cycle, no read_req.
  - start during RUN is ignored (count and address unchanged).
- Reset mid-run: resetn low after 3 of 8 issued, then stale has_return_data = 1 for 3 pops.
  - Requires 3 get_return_data discards, out_valid = 0, busy = 0.
